// File: rtl/rename_map_pkg.sv
// Shared constants and types for the rename stage.
// ARCH_REG_NUM / ARCH_REG_SEL : architectural register file size / index width
// PHY_REG_NUM  / PHY_REG_SEL  : physical register file size / tag width (same as the freelist)
// map_t                       : one whole rename table, indexed by architectural register
package rename_map_pkg;

  localparam int ARCH_REG_NUM = 32;
  localparam int ARCH_REG_SEL = $clog2(ARCH_REG_NUM);
  localparam int PHY_REG_NUM  = 64;
  localparam int PHY_REG_SEL  = $clog2(PHY_REG_NUM);

  typedef logic [ARCH_REG_SEL-1:0] areg_t;
  typedef logic [PHY_REG_SEL-1:0]  ptag_t;
  typedef ptag_t [ARCH_REG_NUM-1:0] map_t;

  // Identity mapping: architectural register i lives in physical register i.
  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < ARCH_REG_NUM; i++) begin
      m[i] = ptag_t'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/map_table_2w.sv
// Rename table: ARCH_REG_NUM entries of PHY_REG_SEL-bit physical tags.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset (table -> identity)
//   rd_addr0..3/rd_data0..3 : four combinational read ports
//   we1/wa1/wd1, we2/wa2/wd2 : two write ports; port 2 wins on the same address
//   load/load_data        : bulk replace of the whole table, beats both write ports
//   contents              : the whole table, for bulk copy and extra lookups
module map_table_2w
  import rename_map_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  areg_t rd_addr0,
  input  areg_t rd_addr1,
  input  areg_t rd_addr2,
  input  areg_t rd_addr3,
  output ptag_t rd_data0,
  output ptag_t rd_data1,
  output ptag_t rd_data2,
  output ptag_t rd_data3,
  input  logic  we1,
  input  areg_t wa1,
  input  ptag_t wd1,
  input  logic  we2,
  input  areg_t wa2,
  input  ptag_t wd2,
  input  logic  load,
  input  map_t  load_data,
  output map_t  contents
);

  map_t mem;

  // The second write is issued after the first, so it overrides it when the
  // addresses collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= identity_map();
    end else if (load) begin
      mem <= load_data;
    end else begin
      if (we1) mem[wa1] <= wd1;
      if (we2) mem[wa2] <= wd2;
    end
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];
  assign rd_data2 = mem[rd_addr2];
  assign rd_data3 = mem[rd_addr3];
  assign contents = mem;

endmodule

// File: rtl/rename_map.sv
// Two-wide register rename stage fed by the physical-register freelist.
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   invalid1/2, wr_reg_1/2         : decode slot empty / slot writes a destination
//   src1_1, src2_1, src1_2, src2_2 : architectural sources; dst1/dst2 destinations
//   phy_dst1/2, phy_dst1/2_val     : tags handed out by the freelist
//   allocatable, stall_DP, prmiss  : freelist ready, back-end stall, mispredict flush
//   com_val1/2, com_arch1/2, com_phy1/2 : commit ports feeding the committed map
//   rn_*                           : registered renamed group (1-cycle latency)
//   rn_fire                        : combinational accept; decode advances when high
// Handshake: a group is consumed in the cycle rn_fire is 1 and appears on rn_*
// with rn_val1/2 on the next cycle; while stall_DP holds, rn_* stay frozen.
module rename_map
  import rename_map_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       invalid1,
  input  logic       invalid2,
  input  logic       wr_reg_1,
  input  logic       wr_reg_2,
  input  logic [4:0] src1_1,
  input  logic [4:0] src2_1,
  input  logic [4:0] src1_2,
  input  logic [4:0] src2_2,
  input  logic [4:0] dst1,
  input  logic [4:0] dst2,
  input  logic [5:0] phy_dst1,
  input  logic [5:0] phy_dst2,
  input  logic       phy_dst1_val,
  input  logic       phy_dst2_val,
  input  logic       allocatable,
  input  logic       stall_DP,
  input  logic       prmiss,
  input  logic       com_val1,
  input  logic       com_val2,
  input  logic [4:0] com_arch1,
  input  logic [4:0] com_arch2,
  input  logic [5:0] com_phy1,
  input  logic [5:0] com_phy2,
  output logic       rn_val1,
  output logic       rn_val2,
  output logic [5:0] rn_src1_1,
  output logic [5:0] rn_src2_1,
  output logic [5:0] rn_src1_2,
  output logic [5:0] rn_src2_2,
  output logic [5:0] rn_dst1,
  output logic [5:0] rn_dst2,
  output logic [5:0] rn_old_dst1,
  output logic [5:0] rn_old_dst2,
  output logic       rn_fire
);

  logic  fire, wr1, wr2;
  map_t  smap_q, cmap_q, cmap_fwd;
  ptag_t s11, s21, s12_raw, s22_raw, s12, s22, old1, old2;
  ptag_t unused_crd0, unused_crd1, unused_crd2, unused_crd3;
  logic  unused_ok;

  assign fire    = allocatable & ~stall_DP & ~prmiss & ~reset;
  assign rn_fire = fire;
  assign wr1     = ~invalid1 & wr_reg_1;
  assign wr2     = ~invalid2 & wr_reg_2;

  // The per-tag valids from the freelist are already summarised by allocatable.
  assign unused_ok = ^{phy_dst1_val, phy_dst2_val,
                       unused_crd0, unused_crd1, unused_crd2, unused_crd3};

  // Committed map as it will look after this cycle's commits; a flush copies
  // this so that a commit landing in the flush cycle is not lost.
  always_comb begin
    cmap_fwd = cmap_q;
    if (com_val1) cmap_fwd[com_arch1] = com_phy1;
    if (com_val2) cmap_fwd[com_arch2] = com_phy2;
  end

  map_table_2w u_smap (
    .clk       (clk),
    .reset     (reset),
    .rd_addr0  (src1_1),
    .rd_addr1  (src2_1),
    .rd_addr2  (src1_2),
    .rd_addr3  (src2_2),
    .rd_data0  (s11),
    .rd_data1  (s21),
    .rd_data2  (s12_raw),
    .rd_data3  (s22_raw),
    .we1       (fire & wr1),
    .wa1       (dst1),
    .wd1       (phy_dst1),
    .we2       (fire & wr2),
    .wa2       (dst2),
    .wd2       (phy_dst2),
    .load      (prmiss),
    .load_data (cmap_fwd),
    .contents  (smap_q)
  );

  map_table_2w u_cmap (
    .clk       (clk),
    .reset     (reset),
    .rd_addr0  (com_arch1),
    .rd_addr1  (com_arch2),
    .rd_addr2  (com_arch1),
    .rd_addr3  (com_arch2),
    .rd_data0  (unused_crd0),
    .rd_data1  (unused_crd1),
    .rd_data2  (unused_crd2),
    .rd_data3  (unused_crd3),
    .we1       (com_val1),
    .wa1       (com_arch1),
    .wd1       (com_phy1),
    .we2       (com_val2),
    .wa2       (com_arch2),
    .wd2       (com_phy2),
    .load      (1'b0),
    .load_data ('0),
    .contents  (cmap_q)
  );

  // Slot 2 sees slot 1's new destination tag, not the stale table entry.
  assign s12  = (wr1 && src1_2 == dst1) ? phy_dst1 : s12_raw;
  assign s22  = (wr1 && src2_2 == dst1) ? phy_dst1 : s22_raw;
  assign old1 = smap_q[dst1];
  assign old2 = (wr1 && dst2 == dst1) ? phy_dst1 : smap_q[dst2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rn_val1     <= 1'b0;
      rn_val2     <= 1'b0;
      rn_src1_1   <= '0;
      rn_src2_1   <= '0;
      rn_src1_2   <= '0;
      rn_src2_2   <= '0;
      rn_dst1     <= '0;
      rn_dst2     <= '0;
      rn_old_dst1 <= '0;
      rn_old_dst2 <= '0;
    end else if (prmiss) begin
      rn_val1 <= 1'b0;
      rn_val2 <= 1'b0;
    end else if (fire) begin
      rn_val1     <= ~invalid1;
      rn_val2     <= ~invalid2;
      rn_src1_1   <= s11;
      rn_src2_1   <= s21;
      rn_src1_2   <= s12;
      rn_src2_2   <= s22;
      rn_dst1     <= phy_dst1;
      rn_dst2     <= phy_dst2;
      rn_old_dst1 <= old1;
      rn_old_dst2 <= old2;
    end else if (!stall_DP) begin
      // Freelist empty: emit a bubble, leave the payload as is.
      rn_val1 <= 1'b0;
      rn_val2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_map.sv
module tb_rename_map;

  localparam int W = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       invalid1, invalid2, wr_reg_1, wr_reg_2;
  logic [4:0] src1_1, src2_1, src1_2, src2_2, dst1, dst2;
  logic [5:0] phy_dst1, phy_dst2;
  logic       phy_dst1_val, phy_dst2_val, allocatable, stall_DP, prmiss;
  logic       com_val1, com_val2;
  logic [4:0] com_arch1, com_arch2;
  logic [5:0] com_phy1, com_phy2;
  logic       rn_val1, rn_val2, rn_fire;
  logic [5:0] rn_src1_1, rn_src2_1, rn_src1_2, rn_src2_2;
  logic [5:0] rn_dst1, rn_dst2, rn_old_dst1, rn_old_dst2;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  rename_map dut (
    .clk(clk), .reset(reset),
    .invalid1(invalid1), .invalid2(invalid2),
    .wr_reg_1(wr_reg_1), .wr_reg_2(wr_reg_2),
    .src1_1(src1_1), .src2_1(src2_1), .src1_2(src1_2), .src2_2(src2_2),
    .dst1(dst1), .dst2(dst2),
    .phy_dst1(phy_dst1), .phy_dst2(phy_dst2),
    .phy_dst1_val(phy_dst1_val), .phy_dst2_val(phy_dst2_val),
    .allocatable(allocatable), .stall_DP(stall_DP), .prmiss(prmiss),
    .com_val1(com_val1), .com_val2(com_val2),
    .com_arch1(com_arch1), .com_arch2(com_arch2),
    .com_phy1(com_phy1), .com_phy2(com_phy2),
    .rn_val1(rn_val1), .rn_val2(rn_val2),
    .rn_src1_1(rn_src1_1), .rn_src2_1(rn_src2_1),
    .rn_src1_2(rn_src1_2), .rn_src2_2(rn_src2_2),
    .rn_dst1(rn_dst1), .rn_dst2(rn_dst2),
    .rn_old_dst1(rn_old_dst1), .rn_old_dst2(rn_old_dst2),
    .rn_fire(rn_fire)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [W-1:0] pack(input logic v1, input logic v2,
      input logic [5:0] s11, input logic [5:0] s21, input logic [5:0] s12,
      input logic [5:0] s22, input logic [5:0] d1, input logic [5:0] d2,
      input logic [5:0] o1, input logic [5:0] o2);
    return {v1, v2, s11, s21, s12, s22, d1, d2, o1, o2};
  endfunction

  function automatic logic [W-1:0] observed();
    return {rn_val1, rn_val2, rn_src1_1, rn_src2_1, rn_src1_2, rn_src2_2,
            rn_dst1, rn_dst2, rn_old_dst1, rn_old_dst2};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic slot1(input logic inv, input logic wr, input logic [4:0] s1,
      input logic [4:0] s2, input logic [4:0] d, input logic [5:0] p);
    invalid1 = inv; wr_reg_1 = wr; src1_1 = s1; src2_1 = s2; dst1 = d; phy_dst1 = p;
  endtask

  task automatic slot2(input logic inv, input logic wr, input logic [4:0] s1,
      input logic [4:0] s2, input logic [4:0] d, input logic [5:0] p);
    invalid2 = inv; wr_reg_2 = wr; src1_2 = s1; src2_2 = s2; dst2 = d; phy_dst2 = p;
  endtask

  task automatic idle();
    slot1(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 6'd0);
    slot2(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 6'd0);
  endtask

  task automatic commit(input logic v1, input logic [4:0] a1, input logic [5:0] p1,
      input logic v2, input logic [4:0] a2, input logic [5:0] p2);
    com_val1 = v1; com_arch1 = a1; com_phy1 = p1;
    com_val2 = v2; com_arch2 = a2; com_phy2 = p2;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    logic [W-1:0] exp;
    logic [W-1:0] obs;
    checks++;
    obs = observed();
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s obs=%h exp=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    idle();
    phy_dst1_val = 1'b1; phy_dst2_val = 1'b1;
    allocatable = 1'b1; stall_DP = 1'b0; prmiss = 1'b0;
    commit(1'b0, 5'd0, 6'd0, 1'b0, 5'd0, 6'd0);
    cycle();
    cycle();
    check_bit("reset_fire", rn_fire, 1'b0);
    exp_q.push_back('0);
    check_out("reset_outputs");
    reset = 1'b0;

    // basic rename r5 -> 40
    slot1(1'b0, 1'b1, 5'd3, 5'd0, 5'd5, 6'd40);
    #1 check_bit("basic_fire", rn_fire, 1'b1);
    exp_q.push_back(pack(1, 0, 6'd3, 6'd0, 6'd0, 6'd0, 6'd40, 6'd0, 6'd5, 6'd0));
    cycle(); check_out("basic_rename");

    slot1(1'b0, 1'b0, 5'd5, 5'd3, 5'd0, 6'd0);
    exp_q.push_back(pack(1, 0, 6'd40, 6'd3, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0));
    cycle(); check_out("lookup_r5");

    // intra-group dependency on r7
    slot1(1'b0, 1'b1, 5'd1, 5'd2, 5'd7, 6'd41);
    slot2(1'b0, 1'b1, 5'd7, 5'd5, 5'd7, 6'd42);
    exp_q.push_back(pack(1, 1, 6'd1, 6'd2, 6'd41, 6'd40, 6'd41, 6'd42, 6'd7, 6'd41));
    cycle(); check_out("intra_group");

    idle();
    slot1(1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 6'd0);
    exp_q.push_back(pack(1, 0, 6'd42, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0));
    cycle(); check_out("lookup_r7_slot2_wins");

    // stall for three cycles with a new group waiting
    slot1(1'b0, 1'b1, 5'd7, 5'd0, 5'd10, 6'd50);
    stall_DP = 1'b1;
    #1 check_bit("stall_fire", rn_fire, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pack(1, 0, 6'd42, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0));
      cycle(); check_out("stall_hold");
    end
    stall_DP = 1'b0;
    exp_q.push_back(pack(1, 0, 6'd42, 6'd0, 6'd0, 6'd0, 6'd50, 6'd0, 6'd10, 6'd0));
    cycle(); check_out("stall_release");

    slot1(1'b0, 1'b0, 5'd10, 5'd0, 5'd10, 6'd0);
    exp_q.push_back(pack(1, 0, 6'd50, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd50, 6'd0));
    cycle(); check_out("lookup_r10");

    // freelist empty
    slot1(1'b0, 1'b1, 5'd10, 5'd0, 5'd11, 6'd51);
    allocatable = 1'b0;
    #1 check_bit("noalloc_fire", rn_fire, 1'b0);
    cycle();
    check_bit("noalloc_val1", rn_val1, 1'b0);
    check_bit("noalloc_val2", rn_val2, 1'b0);
    allocatable = 1'b1;
    slot1(1'b0, 1'b0, 5'd11, 5'd0, 5'd11, 6'd0);
    exp_q.push_back(pack(1, 0, 6'd11, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd11, 6'd0));
    cycle(); check_out("noalloc_map_unchanged");

    // flush with nothing committed
    idle();
    slot1(1'b0, 1'b1, 5'd0, 5'd0, 5'd13, 6'd53);
    prmiss = 1'b1;
    #1 check_bit("prmiss_fire", rn_fire, 1'b0);
    cycle();
    check_bit("prmiss_val1", rn_val1, 1'b0);
    prmiss = 1'b0;
    slot1(1'b0, 1'b0, 5'd5, 5'd7, 5'd13, 6'd0);
    exp_q.push_back(pack(1, 0, 6'd5, 6'd7, 6'd0, 6'd0, 6'd0, 6'd0, 6'd13, 6'd0));
    cycle(); check_out("prmiss_restore");

    // rename r5 -> 46, then flush with a same-cycle commit of r5 -> 40
    slot1(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 6'd46);
    slot2(1'b0, 1'b0, 5'd3, 5'd5, 5'd0, 6'd0);
    exp_q.push_back(pack(1, 1, 6'd0, 6'd0, 6'd3, 6'd46, 6'd46, 6'd0, 6'd5, 6'd0));
    cycle(); check_out("src2_bypass");
    idle();
    prmiss = 1'b1;
    commit(1'b1, 5'd5, 6'd40, 1'b0, 5'd0, 6'd0);
    cycle();
    check_bit("prmiss_commit_val2", rn_val2, 1'b0);
    prmiss = 1'b0;
    commit(1'b0, 5'd0, 6'd0, 1'b0, 5'd0, 6'd0);
    slot1(1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 6'd0);
    exp_q.push_back(pack(1, 0, 6'd40, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0));
    cycle(); check_out("prmiss_forwarded_commit");

    // dual commit to r9, port 2 wins, then flush
    idle();
    commit(1'b1, 5'd9, 6'd44, 1'b1, 5'd9, 6'd45);
    cycle();
    commit(1'b0, 5'd0, 6'd0, 1'b0, 5'd0, 6'd0);
    prmiss = 1'b1;
    cycle();
    prmiss = 1'b0;
    slot1(1'b0, 1'b0, 5'd9, 5'd5, 5'd0, 6'd0);
    exp_q.push_back(pack(1, 0, 6'd45, 6'd40, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0));
    cycle(); check_out("dual_commit");

    // reset in the middle of a stall
    slot1(1'b0, 1'b1, 5'd0, 5'd0, 5'd12, 6'd52);
    exp_q.push_back(pack(1, 0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd52, 6'd0, 6'd12, 6'd0));
    cycle(); check_out("pre_stall_rename");
    idle();
    stall_DP = 1'b1;
    exp_q.push_back(pack(1, 0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd52, 6'd0, 6'd12, 6'd0));
    cycle(); check_out("stall_before_reset");
    reset = 1'b1;
    #1;
    check_bit("async_reset_val1", rn_val1, 1'b0);
    check_bit("async_reset_fire", rn_fire, 1'b0);
    exp_q.push_back('0);
    check_out("async_reset_outputs");
    #1;
    reset = 1'b0;
    stall_DP = 1'b0;
    slot1(1'b0, 1'b0, 5'd5, 5'd12, 5'd9, 6'd0);
    exp_q.push_back(pack(1, 0, 6'd5, 6'd12, 6'd0, 6'd0, 6'd0, 6'd0, 6'd9, 6'd0));
    cycle(); check_out("post_reset_identity");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL leftover_queue obs=%0d exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
